// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_stage
//  Purpose  : Registers ALU result/zero-flag pairs into a 2-entry skid buffer
//             with a valid/ready handshake toward writeback, keeps a
//             saturating count of zero results and a sticky flag-mismatch
//             error.
//  Options  : RESULT_PARITY_EN - adds out_parity (even parity of the entry's
//             result word, computed on accept and stored with the entry).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_flag,
    output logic [CNT_W-1:0] zero_cnt,
    output logic             flag_err,
`ifdef RESULT_PARITY_EN
    output logic             out_parity,
`endif
    input  logic             clr
);

    // Entry layout: {[parity,] flag, result}
`ifdef RESULT_PARITY_EN
    localparam int c_ENT_W = WIDTH + 2;
`else
    localparam int c_ENT_W = WIDTH + 1;
`endif

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_ENT_W-1:0]   r_main;
    logic [c_ENT_W-1:0]   r_skid;
    logic [CNT_W-1:0]     r_zero_cnt;
    logic                 r_flag_err;

    logic                 w_accept;
    logic                 w_send;
    logic                 w_in_zero;
    logic [c_ENT_W-1:0]   w_in_entry;

    // in_ready depends only on the state register (and is held low in reset),
    // so there is no combinational path from out_ready back upstream.
    assign in_ready  = (r_state != S_FULL) && !rst;
    assign out_valid = (r_state != S_EMPTY);

    assign w_accept  = in_valid && in_ready;
    assign w_send    = out_valid && out_ready;
    assign w_in_zero = (in_result == {WIDTH{1'b0}});

`ifdef RESULT_PARITY_EN
    assign w_in_entry = {^in_result, in_flag, in_result};
    assign out_parity = r_main[WIDTH+1];
`else
    assign w_in_entry = {in_flag, in_result};
`endif

    assign out_result = r_main[WIDTH-1:0];
    assign out_flag   = r_main[WIDTH];
    assign zero_cnt   = r_zero_cnt;
    assign flag_err   = r_flag_err;

    // Skid-buffer control: main feeds the output, skid catches the one extra
    // entry accepted while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state <= S_ONE;
                        r_main  <= w_in_entry;
                    end
                end
                S_ONE: begin
                    if (w_accept && !w_send) begin
                        r_state <= S_FULL;
                        r_skid  <= w_in_entry;
                    end else if (w_accept && w_send) begin
                        r_main  <= w_in_entry;
                    end else if (w_send) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_send) begin
                        r_state <= S_ONE;
                        r_main  <= r_skid;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

    // Zero-result statistics and sticky flag check; clr overrides any
    // contribution from an accept in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero_cnt <= '0;
            r_flag_err <= 1'b0;
        end else if (clr) begin
            r_zero_cnt <= '0;
            r_flag_err <= 1'b0;
        end else if (w_accept) begin
            if (in_flag && (r_zero_cnt != c_CNT_MAX)) begin
                r_zero_cnt <= r_zero_cnt + c_CNT_ONE;
            end
            if (in_flag != w_in_zero) begin
                r_flag_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_stage
//  Purpose  : Self-checking bench for alu_result_stage: directed scenarios
//             plus a randomized run against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_flag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_flag;
    logic [CNT_W-1:0] zero_cnt;
    logic             flag_err;
    logic             clr;
`ifdef RESULT_PARITY_EN
    logic             out_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO of {flag, result}, counter and sticky error.
    logic [WIDTH:0] q[$];
    int             m_zcnt;
    logic           m_err;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flag    (in_flag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flag   (out_flag),
        .zero_cnt   (zero_cnt),
        .flag_err   (flag_err),
`ifdef RESULT_PARITY_EN
        .out_parity (out_parity),
`endif
        .clr        (clr)
    );

    // Advance one clock and update the model from the inputs presented.
    task automatic tick();
        bit acc, snd;
        acc = in_valid && (q.size() < 2);
        snd = out_ready && (q.size() > 0);
        @(posedge clk);
        if (snd) void'(q.pop_front());
        if (acc) q.push_back({in_flag, in_result});
        if (clr) begin
            m_zcnt = 0;
            m_err  = 1'b0;
        end else if (acc) begin
            if (in_flag && m_zcnt < CNT_MAX) m_zcnt++;
            if (in_flag != (in_result == 0)) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_zcnt = 0;
        m_err  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flag = 1'b0;
        out_ready = 1'b0; clr = 1'b0;
        model_reset();
        #3;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_result !== 32'h0 || out_flag !== 1'b0) begin n_fail++; $display("FAIL reset_out_data got=%h/%b exp=0/0", out_result, out_flag); end
        n_checks++; if (zero_cnt !== 8'd0 || flag_err !== 1'b0) begin n_fail++; $display("FAIL reset_stats got=%0d/%b exp=0/0", zero_cnt, flag_err); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_result = 32'h0000_00FF; in_flag = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_result !== 32'h0000_00FF || out_flag !== 1'b0) begin n_fail++; $display("FAIL basic_out got=%b/%h/%b exp=1/000000ff/0", out_valid, out_result, out_flag); end
        n_checks++; if (zero_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_zero_cnt got=%0d exp=0", zero_cnt); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 32'hA; in_flag = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
        in_result = 32'hB;
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_result !== 32'hA) begin n_fail++; $display("FAIL bp_stall_hold got=%b/%h exp=1/0000000a", out_valid, out_result); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_comb_ready got=%b exp=0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_result !== 32'hB) begin n_fail++; $display("FAIL bp_second got=%b/%h exp=1/0000000b", out_valid, out_result); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_zero_saturation();
        out_ready = 1'b1;
        clr = 1'b1; tick(); clr = 1'b0;
        in_valid = 1'b1; in_result = '0; in_flag = 1'b1;
        repeat (254) tick();
        n_checks++; if (zero_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254 got=%0d exp=254", zero_cnt); end
        tick();
        n_checks++; if (zero_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255 got=%0d exp=255", zero_cnt); end
        repeat (45) tick();
        n_checks++; if (zero_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got=%0d exp=255", zero_cnt); end
        n_checks++; if (flag_err !== 1'b0) begin n_fail++; $display("FAIL sat_no_err got=%b exp=0", flag_err); end
        clr = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        n_checks++; if (zero_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clr got=%0d exp=0", zero_cnt); end
        tick();
    endtask

    task automatic test_flag_err();
        out_ready = 1'b1;
        in_valid = 1'b1; in_result = 32'h0000_0001; in_flag = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (flag_err !== 1'b1) begin n_fail++; $display("FAIL err_set got=%b exp=1", flag_err); end
        n_checks++; if (out_flag !== 1'b1 || out_result !== 32'h1) begin n_fail++; $display("FAIL err_forward got=%b/%h exp=1/00000001", out_flag, out_result); end
        repeat (3) tick();
        n_checks++; if (flag_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", flag_err); end
        clr = 1'b1; tick(); clr = 1'b0;
        n_checks++; if (flag_err !== 1'b0) begin n_fail++; $display("FAIL err_clr got=%b exp=0", flag_err); end
        // clr wins over an erroring accept, data still flows
        clr = 1'b1; in_valid = 1'b1; in_result = 32'h5; in_flag = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        n_checks++; if (flag_err !== 1'b0 || zero_cnt !== 8'd0) begin n_fail++; $display("FAIL err_clr_prio got=%b/%0d exp=0/0", flag_err, zero_cnt); end
        n_checks++; if (out_valid !== 1'b1 || out_result !== 32'h5) begin n_fail++; $display("FAIL err_clr_data got=%b/%h exp=1/00000005", out_valid, out_result); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 32'h1; in_flag = 1'b0;
        tick();
        in_result = 32'h2;
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0 || out_result !== 32'h1) begin n_fail++; $display("FAIL mid_full got=%b/%h exp=0/00000001", in_ready, out_result); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_result !== 32'h0) begin n_fail++; $display("FAIL mid_async got=%b/%h exp=0/00000000", out_valid, out_result); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++; if (in_ready !== 1'b1 || zero_cnt !== 8'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release got=%b/%0d/%b exp=1/0/0", in_ready, zero_cnt, out_valid); end
        in_valid = 1'b1; in_result = 32'h3;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_result !== 32'h3) begin n_fail++; $display("FAIL mid_first got=%b/%h exp=1/00000003", out_valid, out_result); end
        out_ready = 1'b1;
        tick();
    endtask

`ifdef RESULT_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1; in_valid = 1'b1; in_flag = 1'b0;
        in_result = 32'h0000_0007;
        tick();
        n_checks++; if (out_parity !== 1'b1) begin n_fail++; $display("FAIL parity_7 got=%b exp=1", out_parity); end
        in_result = 32'h0000_0003;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_3 got=%b exp=0", out_parity); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [WIDTH:0] h;
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_result = ($urandom_range(0, 3) == 0) ? 32'h0 : WIDTH'($urandom);
            in_flag   = (in_result == 0) ^ ($urandom_range(0, 63) == 0);
            clr       = ($urandom_range(0, 99) == 0);
            tick();
            n_checks++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, q.size() > 0); end
            n_checks++; if (in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                h = q[0];
                n_checks++; if ({out_flag, out_result} !== h) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%b/%h exp=%b/%h", i, out_flag, out_result, h[WIDTH], h[WIDTH-1:0]); end
`ifdef RESULT_PARITY_EN
                n_checks++; if (out_parity !== ^h[WIDTH-1:0]) begin n_fail++; $display("FAIL rnd_parity cyc=%0d got=%b exp=%b", i, out_parity, ^h[WIDTH-1:0]); end
`endif
            end
            n_checks++; if (int'(zero_cnt) != m_zcnt) begin n_fail++; $display("FAIL rnd_zero_cnt cyc=%0d got=%0d exp=%0d", i, zero_cnt, m_zcnt); end
            n_checks++; if (flag_err !== m_err) begin n_fail++; $display("FAIL rnd_flag_err cyc=%0d got=%b exp=%b", i, flag_err, m_err); end
        end
        in_valid = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_saturation();
        test_flag_err();
        test_reset_mid();
`ifdef RESULT_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
